// File: rtl/ioctl_pkg.sv
// Shared types and constants for the HPS ioctl download/upload responders.
// File indices match the ones used by the ROM/font download path.
package ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_FETCH  = 3'd3,
    ST_DONE   = 3'd4
  } upl_state_t;

  localparam logic [7:0] IDX_BIOS    = 8'd0;
  localparam logic [7:0] IDX_FONT    = 8'd1;
  localparam logic [7:0] IDX_CAPTURE = 8'd2;

  // True when a 25-bit HPS byte address falls inside a 2**addr_w byte RAM.
  function automatic logic addr_in_range(input logic [24:0] addr, input int unsigned addr_w);
    return ((addr >> addr_w) == 25'd0);
  endfunction

endpackage

// File: rtl/ioctl_rd_pipe.sv
// MEM_LAT-deep valid shift register: raises capture exactly when RAM data
// for a launched read is present on mem_q.
module ioctl_rd_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic flush,
  input  logic launch,
  output logic capture
);

  logic [MEM_LAT-1:0] valid_r;

  // Shift launched reads along; flush discards in-flight fetches on abort
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      valid_r <= {MEM_LAT{1'b0}};
    end else if (flush) begin
      valid_r <= {MEM_LAT{1'b0}};
    end else begin
      valid_r[0] <= launch;
      for (int i = 1; i < MEM_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  assign capture = valid_r[MEM_LAT-1];

endmodule

// File: rtl/ioctl_upload_responder.sv
// Core-side responder for HPS ioctl uploads: requests an upload on save_req
// and answers each ioctl_rd strobe with one byte fetched from core RAM.
module ioctl_upload_responder
  import ioctl_pkg::*;
#(
  parameter logic [7:0]  UPLOAD_INDEX = IDX_CAPTURE,
  parameter int          ADDR_W       = 14,
  parameter int          MEM_LAT      = 1,
  parameter logic [7:0]  PAD_BYTE     = 8'hFF,
  parameter logic [23:0] REQ_TIMEOUT  = 24'd12_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              save_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic              ioctl_upload_req,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  upl_state_t        state_r, state_s;
  logic [23:0]       cnt_r, cnt_s;
  logic              err_r, err_s;
  logic [7:0]        din_r, din_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              upload_req_r, busy_r, done_r;
  logic              mem_rd_s, flush_s, capture_s, in_range_s;

  ioctl_rd_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_pipe (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (flush_s),
    .launch  (mem_rd_s),
    .capture (capture_s)
  );

  // Next-state, fetch issue and data capture decisions
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    err_s      = err_r;
    din_s      = din_r;
    addr_s     = addr_r;
    mem_rd_s   = 1'b0;
    flush_s    = 1'b0;
    in_range_s = addr_in_range(ioctl_addr, ADDR_W);
    case (state_r)
      ST_IDLE: begin
        if (save_req) begin
          state_s = ST_REQ;
          err_s   = 1'b0;
          cnt_s   = 24'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ioctl_upload && (ioctl_index == UPLOAD_INDEX)) begin
          state_s = ST_ACTIVE;
        end else if (cnt_r == (REQ_TIMEOUT - 24'd1)) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 24'd1;
        end
      end
      ST_ACTIVE: begin
        // An upload fall beats a simultaneous read strobe
        if (!ioctl_upload) begin
          state_s = ST_DONE;
          flush_s = 1'b1;
        end else if (ioctl_rd) begin
          addr_s = ioctl_addr[ADDR_W-1:0];
          if (in_range_s) begin
            mem_rd_s = 1'b1;
            state_s  = ST_FETCH;
          end else begin
            din_s = PAD_BYTE;
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_FETCH: begin
        if (!ioctl_upload) begin
          state_s = ST_DONE;
          flush_s = 1'b1;
        end else begin
          if (ioctl_rd) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          if (capture_s) begin
            din_s   = mem_q;
            state_s = ST_ACTIVE;
          end else begin
            state_s = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 24'd0;
      err_r        <= 1'b0;
      din_r        <= 8'h00;
      addr_r       <= {ADDR_W{1'b0}};
      upload_req_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      err_r        <= err_s;
      din_r        <= din_s;
      addr_r       <= addr_s;
      upload_req_r <= (state_s == ST_REQ);
      busy_r       <= (state_s == ST_REQ) || (state_s == ST_ACTIVE) || (state_s == ST_FETCH);
      done_r       <= (state_s == ST_DONE);
    end
  end

  // Read address and strobe go out in the strobe cycle itself
  assign mem_rd           = mem_rd_s;
  assign mem_addr         = mem_rd_s ? ioctl_addr[ADDR_W-1:0] : addr_r;
  assign ioctl_upload_req = upload_req_r;
  assign ioctl_din        = din_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign err              = err_r;

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Directed bench: two responders (MEM_LAT 1 and 3, short timeout) share the
// HPS-side stimulus, each with its own RAM model.
module tb_ioctl_upload_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        save_req = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;

  logic        req_a, mem_rd_a, busy_a, done_a, err_a;
  logic [7:0]  din_a, q_a;
  logic [13:0] mem_addr_a;
  logic        req_b, mem_rd_b, busy_b, done_b, err_b;
  logic [7:0]  din_b, q_b1, q_b2, q_b3;
  logic [13:0] mem_addr_b;

  logic [7:0]  ram [0:16383];
  int          rd_cnt_a = 0;
  int          rd_cnt_b = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          snap_a, snap_b;

  always #5 clk = ~clk;

  ioctl_upload_responder #(.MEM_LAT(1), .REQ_TIMEOUT(24'd16)) dut_a (
    .clk_sys(clk), .reset(reset), .save_req(save_req), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_upload_req(req_a), .ioctl_din(din_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
    .mem_q(q_a), .busy(busy_a), .done(done_a), .err(err_a));

  ioctl_upload_responder #(.MEM_LAT(3), .REQ_TIMEOUT(24'd16)) dut_b (
    .clk_sys(clk), .reset(reset), .save_req(save_req), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_upload_req(req_b), .ioctl_din(din_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_q(q_b3), .busy(busy_b), .done(done_b), .err(err_b));

  // RAM models: data is only valid exactly MEM_LAT cycles after mem_rd
  initial begin
    q_a = 8'hEE; q_b1 = 8'hEE; q_b2 = 8'hEE; q_b3 = 8'hEE;
  end
  always @(posedge clk) begin
    q_a  <= mem_rd_a ? ram[mem_addr_a] : 8'hEE;
    q_b1 <= mem_rd_b ? ram[mem_addr_b] : 8'hEE;
    q_b2 <= q_b1;
    q_b3 <= q_b2;
    if (mem_rd_a) rd_cnt_a <= rd_cnt_a + 1;
    if (mem_rd_b) rd_cnt_b <= rd_cnt_b + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    tick(2);
    n_checks++;
    if ({req_a, busy_a, done_a, err_a, din_a, mem_rd_a, mem_addr_a} !== 27'd0) begin
      n_fail++; $display("FAIL reset_a: got %h want 0", {req_a, busy_a, done_a, err_a, din_a, mem_rd_a, mem_addr_a});
    end
    n_checks++;
    if ({req_b, busy_b, done_b, err_b, din_b, mem_rd_b, mem_addr_b} !== 27'd0) begin
      n_fail++; $display("FAIL reset_b: got %h want 0", {req_b, busy_b, done_b, err_b, din_b, mem_rd_b, mem_addr_b});
    end
    reset = 1'b0;
    tick(1);
    n_checks++;
    if ({req_a, busy_a, din_a} !== 10'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h want 0", {req_a, busy_a, din_a});
    end
  endtask

  task automatic test_basic_upload;
    save_req = 1'b1;
    tick(1);
    save_req = 1'b0;
    n_checks++;
    if ({req_a, busy_a, req_b} !== 3'b111) begin
      n_fail++; $display("FAIL req_raise: got %b want 111", {req_a, busy_a, req_b});
    end
    ioctl_upload = 1'b1; ioctl_index = 8'd2;
    tick(1);
    n_checks++;
    if ({req_a, busy_a} !== 2'b01) begin
      n_fail++; $display("FAIL req_drop: got %b want 01", {req_a, busy_a});
    end
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    #1;
    n_checks++;
    if ({mem_rd_a, mem_addr_a, mem_rd_b} !== {1'b1, 14'd5, 1'b1}) begin
      n_fail++; $display("FAIL fetch_issue: got %b/%0d want 1/5", mem_rd_a, mem_addr_a);
    end
    tick(1);
    ioctl_rd = 1'b0;
    n_checks++;
    if (din_a !== 8'h00) begin
      n_fail++; $display("FAIL din_early: got %h want 00", din_a);
    end
    tick(1);
    n_checks++;
    if (din_a !== 8'hA7) begin
      n_fail++; $display("FAIL din_lat1: got %h want a7", din_a);
    end
    tick(2);
    n_checks++;
    if (din_b !== 8'hA7) begin
      n_fail++; $display("FAIL din_lat3: got %h want a7", din_b);
    end
    ioctl_rd = 1'b1; ioctl_addr = 25'd300;
    tick(1);
    ioctl_rd = 1'b0;
    tick(1);
    n_checks++;
    if (din_a !== 8'h10) begin
      n_fail++; $display("FAIL din_addr300_a: got %h want 10", din_a);
    end
    tick(2);
    n_checks++;
    if (din_b !== 8'h10) begin
      n_fail++; $display("FAIL din_addr300_b: got %h want 10", din_b);
    end
  endtask

  task automatic test_out_of_range;
    ioctl_rd = 1'b1; ioctl_addr = 25'd16384;
    #1;
    n_checks++;
    if ({mem_rd_a, mem_rd_b} !== 2'b00) begin
      n_fail++; $display("FAIL oor_no_fetch: got %b want 00", {mem_rd_a, mem_rd_b});
    end
    tick(1);
    n_checks++;
    if ({din_a, din_b} !== 16'hFFFF) begin
      n_fail++; $display("FAIL oor_pad: got %h want ffff", {din_a, din_b});
    end
    ioctl_addr = 25'd16383;
    #1;
    n_checks++;
    if ({mem_rd_a, mem_addr_a} !== {1'b1, 14'h3FFF}) begin
      n_fail++; $display("FAIL last_addr_issue: got %b/%h want 1/3fff", mem_rd_a, mem_addr_a);
    end
    tick(1);
    ioctl_rd = 1'b0;
    tick(1);
    n_checks++;
    if (din_a !== 8'hC3) begin
      n_fail++; $display("FAIL last_addr_data: got %h want c3", din_a);
    end
    tick(2);
    ioctl_rd = 1'b1; ioctl_addr = 25'h1FF_FFFF;
    tick(1);
    ioctl_rd = 1'b0;
    n_checks++;
    if ({din_a, din_b} !== 16'hFFFF) begin
      n_fail++; $display("FAIL max_addr_pad: got %h want ffff", {din_a, din_b});
    end
  endtask

  task automatic test_upload_end;
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    tick(1);
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    tick(1);
    n_checks++;
    if ({done_a, busy_a, done_b, busy_b} !== 4'b1010) begin
      n_fail++; $display("FAIL done_pulse: got %b want 1010", {done_a, busy_a, done_b, busy_b});
    end
    tick(1);
    n_checks++;
    if ({done_a, done_b} !== 2'b00) begin
      n_fail++; $display("FAIL done_single: got %b want 00", {done_a, done_b});
    end
    tick(1);
    n_checks++;
    if ({din_a, din_b} !== 16'hFFFF) begin
      n_fail++; $display("FAIL abort_keeps_din: got %h want ffff", {din_a, din_b});
    end
  endtask

  task automatic test_foreign_and_timeout;
    snap_a = rd_cnt_a; snap_b = rd_cnt_b;
    ioctl_upload = 1'b1; ioctl_index = 8'd1; ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick(3);
    ioctl_rd = 1'b0;
    n_checks++;
    if ({busy_a, req_a, din_a} !== {2'b00, 8'hFF}) begin
      n_fail++; $display("FAIL foreign_idle: got %b%b/%h want 00/ff", busy_a, req_a, din_a);
    end
    save_req = 1'b1;
    tick(1);
    save_req = 1'b0; ioctl_rd = 1'b1;
    tick(15);
    ioctl_rd = 1'b0;
    n_checks++;
    if ({req_a, busy_a, err_a} !== 3'b110) begin
      n_fail++; $display("FAIL req_before_timeout: got %b want 110", {req_a, busy_a, err_a});
    end
    tick(1);
    n_checks++;
    if ({req_a, busy_a, err_a, req_b, err_b} !== 5'b00101) begin
      n_fail++; $display("FAIL timeout: got %b want 00101", {req_a, busy_a, err_a, req_b, err_b});
    end
    n_checks++;
    if ((rd_cnt_a - snap_a) !== 0 || (rd_cnt_b - snap_b) !== 0) begin
      n_fail++; $display("FAIL foreign_no_fetch: got %0d/%0d want 0/0", rd_cnt_a - snap_a, rd_cnt_b - snap_b);
    end
    ioctl_upload = 1'b0; ioctl_index = 8'd2; save_req = 1'b1;
    tick(1);
    save_req = 1'b0;
    n_checks++;
    if ({err_a, req_a, err_b} !== 3'b010) begin
      n_fail++; $display("FAIL err_clear: got %b want 010", {err_a, req_a, err_b});
    end
    ioctl_upload = 1'b1;
    tick(1);
  endtask

  task automatic test_overlap;
    snap_b = rd_cnt_b;
    ioctl_rd = 1'b1; ioctl_addr = 25'd9;
    tick(1);
    ioctl_addr = 25'd10;
    tick(1);
    ioctl_rd = 1'b0;
    n_checks++;
    if ({err_a, err_b} !== 2'b11) begin
      n_fail++; $display("FAIL overlap_err: got %b want 11", {err_a, err_b});
    end
    tick(1);
    n_checks++;
    if (din_b !== 8'hFF) begin
      n_fail++; $display("FAIL overlap_early: got %h want ff", din_b);
    end
    tick(1);
    n_checks++;
    if (din_b !== 8'h35) begin
      n_fail++; $display("FAIL overlap_data: got %h want 35", din_b);
    end
    n_checks++;
    if ((rd_cnt_b - snap_b) !== 1) begin
      n_fail++; $display("FAIL overlap_rd_count: got %0d want 1", rd_cnt_b - snap_b);
    end
  endtask

  task automatic test_reset_mid_fetch;
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick(1);
    ioctl_rd = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({req_a, busy_a, done_a, err_a, din_a, mem_rd_a, mem_addr_a,
         req_b, busy_b, done_b, err_b, din_b, mem_rd_b, mem_addr_b} !== 54'd0) begin
      n_fail++; $display("FAIL async_reset: got %h/%h want 0", {req_a, busy_a, err_a, din_a}, {req_b, busy_b, err_b, din_b});
    end
    tick(1);
    reset = 1'b0;
    tick(1);
    n_checks++;
    if ({busy_a, din_a, busy_b, din_b} !== 18'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want 0", {busy_a, din_a, busy_b, din_b});
    end
    save_req = 1'b1;
    tick(1);
    save_req = 1'b0;
    n_checks++;
    if ({req_a, req_b} !== 2'b11) begin
      n_fail++; $display("FAIL post_reset_req: got %b want 11", {req_a, req_b});
    end
    ioctl_upload = 1'b0;
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = i[7:0] ^ 8'h3C;
    end
    ram[5] = 8'hA7;
    test_reset;
    test_basic_upload;
    test_out_of_range;
    test_upload_end;
    test_foreign_and_timeout;
    test_overlap;
    test_reset_mid_fetch;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_responder.md
Name: ioctl_upload_responder

Overview:
- Core-side responder for the HPS ioctl upload path, the reverse direction of the ROM/font download path.
- On a save request from `system`, it asks the HPS to start an upload. It then answers each `ioctl_rd` strobe by fetching one byte from a core RAM read port and presenting it on `ioctl_din`.
- Sits in the emu top between `hps_io` and the `system` RAM (input-log / capture buffer).

Parameters:
- UPLOAD_INDEX, 8'd2, `ioctl_index` value this block answers to.
- ADDR_W, 14, RAM address width; RAM depth is 2**ADDR_W bytes.
- MEM_LAT, 1, RAM read latency in cycles (1..3).
- PAD_BYTE, 8'hFF, value returned for addresses at or beyond 2**ADDR_W.
- REQ_TIMEOUT, 24'd12_000_000, cycles to wait for `ioctl_upload` after a request before giving up.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- save_req  in  1  one-cycle pulse from `system`: start an upload.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_index  in  8  HPS file index.
- ioctl_rd  in  1  one-cycle byte read strobe from HPS.
- ioctl_addr  in  25  byte address accompanying `ioctl_rd`.
- ioctl_upload_req  out  1  request to HPS to begin upload.
- ioctl_din  out  8  byte returned to HPS.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd  out  1  RAM read enable, one cycle per fetch.
- mem_q  in  8  RAM read data, valid MEM_LAT cycles after `mem_rd`.
- busy  out  1  high from an accepted `save_req` until upload end or timeout.
- done  out  1  one-cycle pulse when `ioctl_upload` falls after an active upload.
- err  out  1  sticky: timeout or overlapping read; cleared only by the next accepted `save_req`.

Behaviour:
- Reset values: all outputs 0, `ioctl_din` = 8'h00, state IDLE, timeout counter 0.
- States: IDLE, REQ, ACTIVE, FETCH, DONE.
- IDLE:
  - `save_req` moves to REQ, clears `err`, loads the timeout counter.
  - `save_req` in any other state is ignored.
- REQ:
  - `ioctl_upload_req` = 1 and `busy` = 1.
  - `ioctl_upload` = 1 with `ioctl_index` == UPLOAD_INDEX moves to ACTIVE and drops `ioctl_upload_req` the same cycle.
  - Counter reaching REQ_TIMEOUT−1 moves to IDLE with `err` = 1.
- ACTIVE:
  - `ioctl_rd` = 1 latches `ioctl_addr`.
  - If `ioctl_addr` < 2**ADDR_W: drive `mem_addr` = `ioctl_addr[ADDR_W-1:0]`, pulse `mem_rd` the same cycle, go to FETCH.
  - Otherwise: `ioctl_din` = PAD_BYTE on the next cycle, stay in ACTIVE, no `mem_rd`.
- FETCH:
  - Counts MEM_LAT cycles, then registers `mem_q` into `ioctl_din`.
  - Latency: `ioctl_din` is valid exactly MEM_LAT+1 cycles after `ioctl_rd`.
  - `ioctl_din` holds until the next completed fetch.
  - `ioctl_rd` arriving during FETCH is dropped and sets `err`; the current fetch completes unchanged.
- Upload end:
  - `ioctl_upload` falling in ACTIVE or FETCH aborts any fetch without updating `ioctl_din`.
  - Then go to DONE; DONE pulses `done` for one cycle and returns to IDLE; `busy` falls that same cycle.
- Foreign uploads: while in IDLE or REQ, `ioctl_rd` under an `ioctl_index` other than UPLOAD_INDEX is ignored and `ioctl_din` is unchanged.
- Simultaneous upload fall and `ioctl_rd`: the fall wins, no fetch is issued.
- Reset mid-upload returns to IDLE immediately and `ioctl_din` goes to 0. The HPS side is not notified.
- Timeout counter: 24 bits, counts only in REQ, saturates at REQ_TIMEOUT−1.

Decomposition:
- Shared package `ioctl_pkg`:
  - state enum `upl_state_t`.
  - localparam IDX_BIOS = 0, IDX_FONT = 1, IDX_CAPTURE = 2 (matching the download indices).
- One natural sub-module, `ioctl_rd_pipe`: a MEM_LAT-deep valid shift register that produces the capture strobe for `ioctl_din`.

Test Plan:
- Basic upload, MEM_LAT=1, RAM[5]=8'hA7:
  - `save_req` → `ioctl_upload_req` is high the next cycle.
  - Raise `ioctl_upload` (index 2) → request drops.
  - `ioctl_rd` with addr 5 → `mem_rd`/`mem_addr`=5 the same cycle, `ioctl_din`=8'hA7 two cycles after `ioctl_rd`.
- Out-of-range read: `ioctl_addr` = 16384 → no `mem_rd`, `ioctl_din`=8'hFF the next cycle.
- Timeout: with REQ_TIMEOUT=16, `save_req` and no `ioctl_upload` → after 16 cycles `ioctl_upload_req`=0, `busy`=0, `err`=1. A new `save_req` clears `err`.
- Overlap, MEM_LAT=3: second `ioctl_rd` one cycle after the first → `err`=1, only one `mem_rd`, `ioctl_din` = data of the first address.
- End and foreign index:
  - `ioctl_upload` falls during FETCH → `done` pulses once, `ioctl_din` keeps its prior value.
  - A separate upload with index 1 and `ioctl_rd` strobes → no `mem_rd`, no state change.
- Async reset asserted mid-FETCH → all outputs 0 within the reset cycle; state IDLE after release.
